glcm_stream_engine: RTL and testbench



---
 rtl/glcm_pkg.sv | 35 +++
 rtl/glcm_pair_scan.sv | 69 ++++++
 rtl/glcm_stream_engine.sv | 183 ++++++++++++++++++
 tb/tb_glcm_stream_engine.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glcm_pkg.sv
// Shared types and helpers for the GLCM stream engine: FSM states, direction codes
// and the direction/distance to (row, column) offset mapping.
package glcm_pkg;

  localparam int DIS_W = 4;

  localparam logic [1:0] DIR_VERT = 2'd1;
  localparam logic [1:0] DIR_HORZ = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  typedef struct packed {
    logic [DIS_W-1:0] dr;
    logic [DIS_W-1:0] dc;
  } offset_t;

  // Codes 0 and 3 both select the diagonal neighbour.
  function automatic offset_t calc_offset(input logic [1:0] dir, input logic [DIS_W-1:0] dis);
    offset_t o;
    o.dr = dis;
    o.dc = dis;
    if (dir == DIR_VERT) begin
      o.dc = '0;
    end else if (dir == DIR_HORZ) begin
      o.dr = '0;
    end
    return o;
  endfunction

endpackage

// File: rtl/glcm_pair_scan.sv
// Raster scan over all (ref, neighbour) pixel pairs for a fixed offset; produces both
// image-store addresses and flags the final pair (or the lack of any pair).
module glcm_pair_scan
  import glcm_pkg::*;
#(
  parameter int IMG_DIM = 16,
  localparam int AXIS_W = $clog2(IMG_DIM),
  localparam int ADDR_W = $clog2(IMG_DIM * IMG_DIM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              advance,
  input  logic [DIS_W-1:0]  dr,
  input  logic [DIS_W-1:0]  dc,
  output logic [ADDR_W-1:0] ref_addr,
  output logic [ADDR_W-1:0] nbr_addr,
  output logic              pair_valid,
  output logic              last
);

  // Wide enough for dis + IMG_DIM so limit arithmetic never wraps.
  localparam int EXT_W = $clog2(IMG_DIM + (1 << DIS_W)) + 1;

  logic [AXIS_W-1:0] r_q, r_d, c_q, c_d;
  logic [EXT_W-1:0]  dim_ext, dr_ext, dc_ext, r_lim, c_lim;
  logic              row_end;

  always_comb begin
    dim_ext    = EXT_W'(IMG_DIM);
    dr_ext     = EXT_W'(dr);
    dc_ext     = EXT_W'(dc);
    pair_valid = (dr_ext < dim_ext) && (dc_ext < dim_ext);
    r_lim      = dim_ext - dr_ext - EXT_W'(1);
    c_lim      = dim_ext - dc_ext - EXT_W'(1);
    row_end    = (EXT_W'(c_q) == c_lim);
    last       = !pair_valid || (row_end && (EXT_W'(r_q) == r_lim));

    r_d = r_q;
    c_d = c_q;
    if (start) begin
      r_d = '0;
      c_d = '0;
    end else if (advance && !last) begin
      if (row_end) begin
        c_d = '0;
        r_d = r_q + AXIS_W'(1);
      end else begin
        c_d = c_q + AXIS_W'(1);
      end
    end
  end

  always_comb begin
    ref_addr = ADDR_W'(r_q) * ADDR_W'(IMG_DIM) + ADDR_W'(c_q);
    nbr_addr = (ADDR_W'(r_q) + ADDR_W'(dr)) * ADDR_W'(IMG_DIM) + ADDR_W'(c_q) + ADDR_W'(dc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end

endmodule

// File: rtl/glcm_stream_engine.sv
// Streams in a square gray-level image, builds its co-occurrence matrix with
// saturating counters (optionally symmetric) and streams the matrix out in packed beats.
module glcm_stream_engine
  import glcm_pkg::*;
#(
  parameter int IMG_DIM   = 16,
  parameter int PIX_W     = 8,
  parameter int GRAY_BITS = 5,
  parameter int CNT_W     = 8,
  parameter int PACK      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_dir,
  input  logic [DIS_W-1:0]      cfg_dis,
  input  logic                  cfg_sym,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [PIX_W-1:0]      pix_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PACK*CNT_W-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int L       = 1 << GRAY_BITS;
  localparam int ENTRIES = L * L;
  localparam int BEATS   = ENTRIES / PACK;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W   = 2 * GRAY_BITS;
  localparam int PIXELS  = IMG_DIM * IMG_DIM;
  localparam int ADDR_W  = $clog2(PIXELS);

  state_t              state_q, state_d;
  offset_t             off_q, off_d;
  logic                sym_q, sym_d;
  logic [ADDR_W-1:0]   load_cnt_q, load_cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  logic [GRAY_BITS-1:0] img_mem [PIXELS];
  logic [CNT_W-1:0]     cnt_q [ENTRIES];
  logic [CNT_W-1:0]     cnt_d [ENTRIES];

  logic                 cfg_hs, pix_hs, out_hs, load_done, beat_last;
  logic [ADDR_W-1:0]    ref_addr, nbr_addr;
  logic                 pair_valid, scan_last, pair_upd;
  logic [GRAY_BITS-1:0] ref_gray, nbr_gray;
  logic [IDX_W-1:0]     idx_a, idx_b;
  logic [1:0]           inc_v;
  logic [PACK*CNT_W-1:0] beat_word;

  generate
    if (PIX_W > GRAY_BITS) begin : g_pix_hi
      logic unused_pix_hi;
      assign unused_pix_hi = ^pix_data[PIX_W-1:GRAY_BITS];
    end
  endgenerate

  assign cfg_hs    = cfg_valid && cfg_ready;
  assign pix_hs    = pix_valid && pix_ready;
  assign out_hs    = out_valid && out_ready;
  assign load_done = pix_hs && (load_cnt_q == ADDR_W'(PIXELS - 1));
  assign beat_last = (beat_q == BEAT_W'(BEATS - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_hs)              state_d = LOAD;
      LOAD:    if (load_done)           state_d = COMPUTE;
      COMPUTE: if (scan_last)           state_d = DRAIN;
      DRAIN:   if (out_hs && beat_last) state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cfg_ready = (state_q == IDLE);
    pix_ready = (state_q == LOAD);
    out_valid = (state_q == DRAIN);
    out_last  = (state_q == DRAIN) && beat_last;
    busy      = (state_q != IDLE);
    out_data  = out_valid ? beat_word : '0;
  end

  always_comb begin
    off_d      = off_q;
    sym_d      = sym_q;
    load_cnt_d = load_cnt_q;
    beat_d     = beat_q;
    if (cfg_hs) begin
      off_d      = calc_offset(cfg_dir, cfg_dis);
      sym_d      = cfg_sym;
      load_cnt_d = '0;
      beat_d     = '0;
    end else begin
      if (pix_hs) load_cnt_d = load_cnt_q + ADDR_W'(1);
      if (out_hs) beat_d     = beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q      <= '0;
      sym_q      <= 1'b0;
      load_cnt_q <= '0;
      beat_q     <= '0;
    end else begin
      off_q      <= off_d;
      sym_q      <= sym_d;
      load_cnt_q <= load_cnt_d;
      beat_q     <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_hs) img_mem[load_cnt_q] <= pix_data[GRAY_BITS-1:0];
  end

  glcm_pair_scan #(
    .IMG_DIM(IMG_DIM)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (cfg_hs),
    .advance   (state_q == COMPUTE),
    .dr        (off_q.dr),
    .dc        (off_q.dc),
    .ref_addr  (ref_addr),
    .nbr_addr  (nbr_addr),
    .pair_valid(pair_valid),
    .last      (scan_last)
  );

  // Asynchronous read keeps one pair per COMPUTE cycle with no pipeline tail into DRAIN.
  assign ref_gray = img_mem[ref_addr];
  assign nbr_gray = img_mem[nbr_addr];
  assign pair_upd = (state_q == COMPUTE) && pair_valid;
  assign idx_a    = {ref_gray, nbr_gray};
  assign idx_b    = {nbr_gray, ref_gray};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W+1:0] sum;
    sum = {2'b00, a} + {{CNT_W{1'b0}}, b};
    return (sum[CNT_W+1:CNT_W] != 2'b00) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // A diagonal entry in symmetric mode matches both indices and so gains 2.
  always_comb begin
    inc_v = 2'b00;
    for (int i = 0; i < ENTRIES; i++) begin
      inc_v = 2'(pair_upd && (IDX_W'(i) == idx_a))
            + 2'(pair_upd && sym_q && (IDX_W'(i) == idx_b));
      cnt_d[i] = cfg_hs ? '0 : sat_add(cnt_q[i], inc_v);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  generate
    for (genvar gi = 0; gi < PACK; gi++) begin : g_pack
      logic [IDX_W-1:0] sel;
      assign sel = IDX_W'(beat_q) * IDX_W'(PACK) + IDX_W'(gi);
      assign beat_word[gi*CNT_W +: CNT_W] = cnt_q[sel];
    end
  endgenerate

endmodule

// File: tb/tb_glcm_stream_engine.sv
// Randomised scoreboard bench: a reference GLCM model queues expected beats, a monitor
// compares every output handshake; a second small instance covers the zero-pair case.
module tb_glcm_stream_engine;

  localparam int IMG_DIM   = 16;
  localparam int PIX_W     = 8;
  localparam int GRAY_BITS = 5;
  localparam int CNT_W     = 8;
  localparam int PACK      = 4;
  localparam int L         = 1 << GRAY_BITS;
  localparam int NBEATS    = L * L / PACK;
  localparam int OW        = PACK * CNT_W;
  localparam int PIXELS    = IMG_DIM * IMG_DIM;
  localparam int MAXC      = (1 << CNT_W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_valid = 1'b0, cfg_ready, cfg_sym = 1'b0;
  logic [1:0]    cfg_dir = 2'd0;
  logic [3:0]    cfg_dis = 4'd0;
  logic          pix_valid = 1'b0, pix_ready;
  logic [PIX_W-1:0] pix_data = '0;
  logic          out_valid, out_ready, out_last, busy;
  logic [OW-1:0] out_data;

  logic          s_cfg_valid = 1'b0, s_cfg_ready, s_cfg_sym = 1'b0;
  logic [1:0]    s_cfg_dir = 2'd0;
  logic [3:0]    s_cfg_dis = 4'd0;
  logic          s_pix_valid = 1'b0, s_pix_ready;
  logic [PIX_W-1:0] s_pix_data = '0;
  logic          s_out_valid, s_out_ready = 1'b1, s_out_last, s_busy;
  logic [OW-1:0] s_out_data;

  always #5 clk = ~clk;

  glcm_stream_engine #(
    .IMG_DIM(IMG_DIM), .PIX_W(PIX_W), .GRAY_BITS(GRAY_BITS), .CNT_W(CNT_W), .PACK(PACK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_dir(cfg_dir), .cfg_dis(cfg_dis),
    .cfg_sym(cfg_sym), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  glcm_stream_engine #(
    .IMG_DIM(8), .PIX_W(PIX_W), .GRAY_BITS(GRAY_BITS), .CNT_W(CNT_W), .PACK(PACK)
  ) u_small (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready), .cfg_dir(s_cfg_dir), .cfg_dis(s_cfg_dis),
    .cfg_sym(s_cfg_sym), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready), .pix_data(s_pix_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_last(s_out_last),
    .busy(s_busy)
  );

  int errors = 0;
  int checks = 0;
  int job_no = 0;
  bit rand_ready = 1'b0;

  logic [OW-1:0]    exp_q[$];
  bit               exp_last_q[$];
  logic [PIX_W-1:0] img [PIXELS];
  int unsigned      mtx [L*L];

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void fill_img(input int mode);
    for (int i = 0; i < PIXELS; i++) begin
      case (mode)
        0:       img[i] = '0;
        1:       img[i] = PIX_W'(i % IMG_DIM);
        2:       img[i] = 8'hE3;
        default: img[i] = PIX_W'($urandom);
      endcase
    end
  endfunction

  function automatic void bump(input int idx);
    if (mtx[idx] < MAXC) mtx[idx] = mtx[idx] + 1;
  endfunction

  function automatic void build_model(input int dir, input int dis, input bit sym);
    int dr, dc, a, b;
    dr = (dir == 2) ? 0 : dis;
    dc = (dir == 1) ? 0 : dis;
    for (int i = 0; i < L*L; i++) mtx[i] = 0;
    for (int r = 0; r + dr < IMG_DIM; r++) begin
      for (int c = 0; c + dc < IMG_DIM; c++) begin
        a = int'(img[r*IMG_DIM + c]) % L;
        b = int'(img[(r+dr)*IMG_DIM + c + dc]) % L;
        bump(a*L + b);
        if (sym) bump(b*L + a);
      end
    end
  endfunction

  function automatic int exp_pairs(input int dim, input int dir, input int dis);
    int dr, dc;
    dr = (dir == 2) ? 0 : dis;
    dc = (dir == 1) ? 0 : dis;
    if (dr >= dim || dc >= dim) return 1;
    return (dim - dr) * (dim - dc);
  endfunction

  function automatic void push_expected();
    logic [OW-1:0] w;
    for (int k = 0; k < NBEATS; k++) begin
      w = '0;
      for (int j = 0; j < PACK; j++) w[j*CNT_W +: CNT_W] = CNT_W'(mtx[k*PACK + j]);
      exp_q.push_back(w);
      exp_last_q.push_back(k == NBEATS - 1);
    end
  endfunction

  // ---------------- output driver and monitor ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  bit            stalled = 1'b0;
  logic [OW-1:0] held_data;
  logic [OW-1:0] exp_d;
  bit            exp_l;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (!out_valid) check("idle_data_zero", out_data, 0);
      if (stalled && out_valid) check("stall_hold", out_data, held_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got 0x%0h, expected no beat", out_data);
        end else begin
          exp_d = exp_q.pop_front();
          exp_l = exp_last_q.pop_front();
          check("beat_data", out_data, exp_d);
          check("beat_last", out_last, exp_l);
        end
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled   = 1'b1;
        held_data = out_data;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_cfg(input int dir, input int dis, input bit sym);
    int g = 0;
    while (!cfg_ready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    check("cfg_ready_before_job", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_dir   = 2'(dir);
    cfg_dis   = 4'(dis);
    cfg_sym   = sym;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("pix_ready_after_cfg", pix_ready, 1);
  endtask

  task automatic load_pixels(input int n);
    int g;
    bit seen;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        pix_valid = 1'b0;
        @(posedge clk); #1;
      end
      pix_valid = 1'b1;
      pix_data  = img[i];
      g = 0;
      seen = 1'b0;
      while (!seen && g < 50) begin
        seen = pix_ready;
        @(posedge clk); #1;
        g++;
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL pix_handshake_timeout: pixel %0d not accepted, expected pix_ready", i);
        pix_valid = 1'b0;
        return;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic finish_job(input int n_pairs);
    int k = 0;
    int g = 0;
    while (!out_valid && k < 5000) begin
      @(posedge clk); #1; k++;
    end
    check("compute_cycles", k, n_pairs);
    while (exp_q.size() != 0 && g < 20000) begin
      @(negedge clk); #1; g++;
    end
    check("beats_left", exp_q.size(), 0);
    @(posedge clk); #1;
    check("cfg_ready_after_last", cfg_ready, 1);
    check("busy_after_last", busy, 0);
  endtask

  task automatic run_job(input int dir, input int dis, input bit sym, input int mode, input bit rr);
    fill_img(mode);
    build_model(dir, dis, sym);
    push_expected();
    rand_ready = rr;
    do_cfg(dir, dis, sym);
    load_pixels(PIXELS);
    finish_job(exp_pairs(IMG_DIM, dir, dis));
    job_no++;
    $display("job %0d: dir=%0d dis=%0d sym=%0d fill=%0d random_ready=%0d pairs=%0d",
             job_no, dir, dis, sym, mode, rr, exp_pairs(IMG_DIM, dir, dis));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready, 1);
    check({tag, "_pix_ready"}, pix_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_busy"},      busy,      0);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    exp_q.delete();
    exp_last_q.delete();
    pix_valid = 1'b0;
    cfg_valid = 1'b0;
    rand_ready = 1'b0;
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset pulse: %s", tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int g, n, k, nz, nb, last_at;
    bit seen;

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(2, 1, 1'b0, 0, 1'b0);
    run_job(2, 1, 1'b0, 1, 1'b0);
    run_job(2, 1, 1'b1, 1, 1'b0);
    run_job(1, 0, 1'b1, 2, 1'b0);
    run_job(0, 15, 1'b0, 3, 1'b0);
    run_job(3, 3, 1'b1, 3, 1'b1);
    run_job(1, 5, 1'b0, 3, 1'b1);

    // Abort in LOAD, then a fresh job.
    fill_img(3);
    do_cfg(2, 2, 1'b1);
    load_pixels(100);
    pulse_reset("mid_load");
    run_job(2, 2, 1'b1, 3, 1'b1);

    // Abort in DRAIN, then a fresh job.
    fill_img(3);
    build_model(1, 1, 1'b1);
    push_expected();
    rand_ready = 1'b1;
    do_cfg(1, 1, 1'b1);
    load_pixels(PIXELS);
    g = 0;
    while (!out_valid && g < 5000) begin
      @(posedge clk); #1; g++;
    end
    check("drain_reached", out_valid, 1);
    repeat (60) @(negedge clk);
    pulse_reset("mid_drain");
    run_job(0, 1, 1'b0, 3, 1'b1);

    // Zero-pair job on the 8x8 instance: dr = dc = 9.
    check("small_cfg_ready", s_cfg_ready, 1);
    s_cfg_dir   = 2'd0;
    s_cfg_dis   = 4'd9;
    s_cfg_sym   = 1'b0;
    s_cfg_valid = 1'b1;
    @(posedge clk); #1;
    s_cfg_valid = 1'b0;
    n = 0;
    g = 0;
    s_pix_valid = 1'b1;
    while (n < 64 && g < 500) begin
      s_pix_data = PIX_W'($urandom);
      seen = s_pix_ready;
      @(posedge clk); #1;
      if (seen) n++;
      g++;
    end
    s_pix_valid = 1'b0;
    check("small_pixels", n, 64);
    k = 0;
    while (!s_out_valid && k < 500) begin
      @(posedge clk); #1; k++;
    end
    check("small_compute_cycles", k, exp_pairs(8, 0, 9));
    nz = 0;
    nb = 0;
    last_at = -1;
    while (s_out_valid && nb < 300) begin
      if (s_out_data != '0) nz++;
      if (s_out_last) last_at = nb;
      nb++;
      @(posedge clk); #1;
    end
    check("small_beats", nb, NBEATS);
    check("small_nonzero_beats", nz, 0);
    check("small_last_index", last_at, NBEATS - 1);
    check("small_cfg_ready_after", s_cfg_ready, 1);
    $display("small job: dir=0 dis=9 beats=%0d compute_cycles=%0d", nb, k);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
